// File: rtl/dma_sink.sv
// dma_sink: captures a 32-word block from a DMA channel into a local buffer,
// flags sequence errors and aborts, and serves registered random reads.
module dma_sink #(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             STATE,
    input  logic [4:0]       COUNT,
    input  logic             ONE,
    input  logic [WIDTH-1:0] DIN,
    input  logic [4:0]       RADDR,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic             BUSY,
    output logic             ERR,
    output logic             ABORT,
    output logic [7:0]       BLK_CNT
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    logic [1:0]       fsm;
    logic [4:0]       exp_addr;
    logic [5:0]       wcnt;
    logic             wr_en;
    logic [WIDTH-1:0] buffer [32];

    // A word is stored only when it is the one the sequence expects next.
    always_comb begin
        wr_en = 1'b0;
        if (STATE && !ONE) begin
            if (fsm == IDLE && COUNT == 5'd0)
                wr_en = 1'b1;
            else if (fsm == RECV && COUNT == exp_addr && wcnt < 6'd32)
                wr_en = 1'b1;
        end
    end

    // Buffer survives reset so a completed block stays readable.
    always_ff @(posedge CLK) begin
        if (!CLR && wr_en)
            buffer[COUNT] <= DIN;
    end

    assign BUSY = (fsm == RECV);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            fsm      <= IDLE;
            exp_addr <= 5'd0;
            wcnt     <= 6'd0;
            VALID    <= 1'b0;
            ERR      <= 1'b0;
            ABORT    <= 1'b0;
            BLK_CNT  <= 8'd0;
            DOUT     <= '0;
        end else begin
            ABORT <= 1'b0;
            DOUT  <= buffer[RADDR];
            case (fsm)
                IDLE: begin
                    if (STATE) begin
                        if (COUNT == 5'd0 && !ONE) begin
                            exp_addr <= 5'd1;
                            wcnt     <= 6'd1;
                            VALID    <= 1'b0;
                            ERR      <= 1'b0;
                            fsm      <= RECV;
                        end else begin
                            ERR <= 1'b1;
                            fsm <= FAULT;
                        end
                    end
                end
                RECV: begin
                    // Channel drop beats completion, which beats the address check.
                    if (!STATE) begin
                        ABORT <= 1'b1;
                        fsm   <= IDLE;
                    end else if (ONE) begin
                        if (wcnt == 6'd32) begin
                            VALID   <= 1'b1;
                            BLK_CNT <= BLK_CNT + 8'd1;
                            fsm     <= DONE;
                        end else begin
                            ERR <= 1'b1;
                            fsm <= FAULT;
                        end
                    end else if (wcnt == 6'd32 && COUNT == 5'd31) begin
                        fsm <= RECV;
                    end else if (COUNT == exp_addr && wcnt < 6'd32) begin
                        exp_addr <= exp_addr + 5'd1;
                        wcnt     <= wcnt + 6'd1;
                    end else begin
                        ERR <= 1'b1;
                        fsm <= FAULT;
                    end
                end
                DONE: begin
                    if (!STATE)
                        fsm <= IDLE;
                end
                default: begin
                    if (!STATE)
                        fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_sink.sv
// Self-checking bench for dma_sink: directed tables, block sequences and
// randomized traffic compared against a word-count based reference model.
module tb_dma_sink;

    localparam int WIDTH = 2;

    logic             CLK = 1'b0;
    logic             CLR = 1'b1;
    logic             STATE = 1'b0;
    logic [4:0]       COUNT = '0;
    logic             ONE = 1'b0;
    logic [WIDTH-1:0] DIN = '0;
    logic [4:0]       RADDR = '0;
    logic [WIDTH-1:0] DOUT;
    logic             VALID;
    logic             BUSY;
    logic             ERR;
    logic             ABORT;
    logic [7:0]       BLK_CNT;

    int checks = 0;
    int errors = 0;

    dma_sink #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .CLR(CLR), .STATE(STATE), .COUNT(COUNT), .ONE(ONE),
        .DIN(DIN), .RADDR(RADDR), .DOUT(DOUT), .VALID(VALID), .BUSY(BUSY),
        .ERR(ERR), .ABORT(ABORT), .BLK_CNT(BLK_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: a block is tracked as a count of words received so far.
    bit         m_recv, m_done, m_fault;
    int         m_n;
    bit         m_valid, m_err, m_abort;
    int         m_blk;
    logic [1:0] m_mem [32];
    bit         m_known [32];
    logic [1:0] m_dout;
    bit         m_dout_known;

    function automatic void model_step(bit clr, bit st, logic [4:0] cnt, bit one,
                                       logic [1:0] din, logic [4:0] raddr);
        logic [1:0] rd;
        bit         rk;
        bit         wr;
        rd = m_mem[raddr];
        rk = m_known[raddr];
        wr = 1'b0;
        if (clr) begin
            m_recv = 0; m_done = 0; m_fault = 0; m_n = 0;
            m_valid = 0; m_err = 0; m_abort = 0; m_blk = 0;
            m_dout = '0; m_dout_known = 1;
            return;
        end
        m_abort = 0;
        if (m_recv) begin
            if (!st) begin
                m_abort = 1; m_recv = 0;
            end else if (one) begin
                m_recv = 0;
                if (m_n == 32) begin
                    m_valid = 1; m_blk = (m_blk + 1) % 256; m_done = 1;
                end else begin
                    m_err = 1; m_fault = 1;
                end
            end else if (m_n == 32 && cnt == 31) begin
                wr = 0;
            end else if (m_n < 32 && int'(cnt) == m_n % 32) begin
                wr = 1; m_n++;
            end else begin
                m_err = 1; m_recv = 0; m_fault = 1;
            end
        end else if (m_done || m_fault) begin
            if (!st) begin m_done = 0; m_fault = 0; end
        end else if (st) begin
            if (cnt == 0 && !one) begin
                wr = 1; m_n = 1; m_recv = 1; m_valid = 0; m_err = 0;
            end else begin
                m_err = 1; m_fault = 1;
            end
        end
        if (wr) begin
            m_mem[cnt] = din;
            m_known[cnt] = 1;
        end
        m_dout = rd;
        m_dout_known = rk;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(bit clr, bit st, logic [4:0] cnt, bit one,
                                 logic [1:0] din, logic [4:0] raddr);
        CLR = clr; STATE = st; COUNT = cnt; ONE = one; DIN = din; RADDR = raddr;
        @(posedge CLK);
        model_step(clr, st, cnt, one, din, raddr);
        #1;
    endtask

    task automatic checkOutput();
        check("model VALID", int'(VALID), int'(m_valid));
        check("model BUSY", int'(BUSY), int'(m_recv));
        check("model ERR", int'(ERR), int'(m_err));
        check("model ABORT", int'(ABORT), int'(m_abort));
        check("model BLK_CNT", int'(BLK_CNT), m_blk);
        if (m_dout_known)
            check("model DOUT", int'(DOUT), int'(m_dout));
    endtask

    task automatic step(bit clr, bit st, logic [4:0] cnt, bit one,
                        logic [1:0] din, logic [4:0] raddr);
        applyStimulus(clr, st, cnt, one, din, raddr);
        checkOutput();
    endtask

    // Nominal block: DIN = COUNT[1:0], then ONE with RADDR=5, then one idle cycle.
    task automatic run_block(int exp_blk);
        for (int c = 0; c < 32; c++) begin
            step(0, 1, 5'(c), 0, 2'(c), 5'(c));
            if (c == 0) check("block start VALID", int'(VALID), 0);
        end
        step(0, 1, 5'd31, 1, 2'd0, 5'd5);
        check("block VALID", int'(VALID), 1);
        check("block ERR", int'(ERR), 0);
        check("block BLK_CNT", int'(BLK_CNT), exp_blk);
        step(0, 0, 5'd0, 0, 2'd0, 5'd5);
        check("block DOUT[5]", int'(DOUT), 1);
        check("block VALID held", int'(VALID), 1);
    endtask

    typedef struct {
        bit         clr, st;
        logic [4:0] cnt;
        bit         one;
        logic [1:0] din;
        logic [4:0] raddr;
        bit         valid, busy, err, abort;
        int         blk;
        bit         dchk;
        logic [1:0] dout;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit st, int cnt, bit one, int din, int raddr,
                                bit valid, bit busy, bit err, bit abort, int blk,
                                bit dchk, int dout);
        vec_t v;
        v.clr = 0; v.st = st; v.cnt = 5'(cnt); v.one = one; v.din = 2'(din);
        v.raddr = 5'(raddr); v.valid = valid; v.busy = busy; v.err = err;
        v.abort = abort; v.blk = blk; v.dchk = dchk; v.dout = 2'(dout);
        tbl.push_back(v);
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_known[i] = 0; end
        m_recv = 0; m_done = 0; m_fault = 0; m_n = 0; m_valid = 0;
        m_err = 0; m_abort = 0; m_blk = 0; m_dout = '0; m_dout_known = 0;

        step(1, 0, 5'd0, 0, 2'd0, 5'd0);
        step(1, 1, 5'd0, 0, 2'd3, 5'd0);
        check("reset VALID", int'(VALID), 0);
        check("reset BUSY", int'(BUSY), 0);
        check("reset ERR", int'(ERR), 0);
        check("reset BLK_CNT", int'(BLK_CNT), 0);
        check("reset DOUT", int'(DOUT), 0);
        step(0, 0, 5'd0, 0, 2'd0, 5'd0);

        run_block(1);

        // Skipped address: 0,1,2,4 then drop STATE; address 4 keeps its old 0.
        add(1, 0, 0, 3, 0, 0, 1, 0, 0, 1, 0, 0);
        add(1, 1, 0, 2, 0, 0, 1, 0, 0, 1, 0, 0);
        add(1, 2, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        add(1, 4, 0, 3, 4, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 4, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 4, 0, 0, 1, 0, 1, 1, 0);
        // Abort after COUNT=10.
        for (int c = 0; c <= 10; c++) add(1, c, 0, c, 0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Premature ONE after 20 writes.
        for (int c = 0; c < 20; c++) add(1, c, 0, c, 0, 0, 1, 0, 0, 1, 0, 0);
        add(1, 20, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].st, tbl[i].cnt, tbl[i].one, tbl[i].din, tbl[i].raddr);
            check($sformatf("tbl[%0d] VALID", i), int'(VALID), int'(tbl[i].valid));
            check($sformatf("tbl[%0d] BUSY", i), int'(BUSY), int'(tbl[i].busy));
            check($sformatf("tbl[%0d] ERR", i), int'(ERR), int'(tbl[i].err));
            check($sformatf("tbl[%0d] ABORT", i), int'(ABORT), int'(tbl[i].abort));
            check($sformatf("tbl[%0d] BLK_CNT", i), int'(BLK_CNT), tbl[i].blk);
            if (tbl[i].dchk)
                check($sformatf("tbl[%0d] DOUT", i), int'(DOUT), int'(tbl[i].dout));
        end

        // Back-to-back blocks after reset; the 256th wraps the counter to zero.
        step(1, 0, 5'd0, 0, 2'd0, 5'd0);
        for (int b = 0; b < 256; b++)
            run_block((b + 1) % 256);
        check("wrap BLK_CNT", int'(BLK_CNT), 0);

        // Reset in the middle of a block.
        for (int c = 0; c < 15; c++) step(0, 1, 5'(c), 0, 2'(c), 5'd0);
        step(1, 1, 5'd15, 0, 2'd3, 5'd7);
        check("clr VALID", int'(VALID), 0);
        check("clr BUSY", int'(BUSY), 0);
        check("clr ERR", int'(ERR), 0);
        check("clr ABORT", int'(ABORT), 0);
        check("clr BLK_CNT", int'(BLK_CNT), 0);
        check("clr DOUT", int'(DOUT), 0);
        step(0, 0, 5'd0, 0, 2'd0, 5'd0);
        check("clr no ABORT", int'(ABORT), 0);
        run_block(1);

        // Randomized traffic, mostly legal with occasional disturbances.
        for (int k = 0; k < 3000; k++) begin
            bit         clr, st, one;
            logic [4:0] cnt;
            clr = ($urandom_range(0, 199) == 0);
            if (m_recv) st = ($urandom_range(0, 39) != 0);
            else        st = ($urandom_range(0, 3) != 0);
            cnt = m_recv ? 5'((m_n < 32) ? m_n : 31) : 5'd0;
            if ($urandom_range(0, 19) == 0) cnt = 5'($urandom_range(0, 31));
            if (m_recv && m_n == 32) one = ($urandom_range(0, 2) == 0);
            else                     one = ($urandom_range(0, 49) == 0);
            step(clr, st, cnt, one, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_sink.md
DMA_SINK -- requirements
Module: dma_sink

Interface
REQ-001 Parameter: WIDTH, default 2, data word width in bits.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: CLR  input  1  reset, synchronous, active-high.
REQ-004 Port: STATE  input  1  channel block-transfer enable, from the DMA channel.
REQ-005 Port: COUNT  input  5  channel word address, 0..31.
REQ-006 Port: ONE  input  1  channel block-complete flag.
REQ-007 Port: DIN  input  WIDTH  data word for address COUNT, valid in the same cycle.
REQ-008 Port: RADDR  input  5  user read address into the block buffer.
REQ-009 Port: DOUT  output  WIDTH  registered read data for RADDR.
REQ-010 Port: VALID  output  1  complete 32-word block held in buffer.
REQ-011 Port: BUSY  output  1  block reception in progress.
REQ-012 Port: ERR  output  1  sticky sequence-error flag.
REQ-013 Port: ABORT  output  1  one-cycle pulse: block abandoned by channel.
REQ-014 Port: BLK_CNT  output  8  count of completed blocks.

Function
REQ-015 Storage: 32 x WIDTH buffer, indexed by COUNT on write and RADDR on read.
REQ-016 FSM states: IDLE, RECV, DONE, FAULT; BUSY=1 only in RECV.
REQ-017 Write strobe: a cycle is a write cycle when STATE=1, ONE=0, and the FSM is in IDLE or RECV with the COUNT check passing.
REQ-018 Internal state: 5-bit expected-address register EXP and 6-bit write counter WCNT.
REQ-019 IDLE, STATE=1, COUNT=0: write DIN at address 0; EXP<=1; WCNT<=1; VALID<=0; ERR<=0; go to RECV.
REQ-020 IDLE, STATE=1, COUNT!=0: no write; ERR<=1; go to FAULT.
REQ-021 IDLE, STATE=0: remain in IDLE; VALID and buffer contents unchanged.
REQ-022 RECV, STATE=1, ONE=0, COUNT==EXP, WCNT<32: write DIN; EXP<=EXP+1 (wraps 31->0); WCNT<=WCNT+1.
REQ-023 RECV, STATE=1, ONE=0, COUNT!=EXP: no write; ERR<=1; go to FAULT.
REQ-024 RECV, STATE=1, ONE=0, COUNT==31, WCNT==32: channel hold cycle; no write, no error; remain in RECV.
REQ-025 RECV, ONE=1, WCNT==32: VALID<=1; BLK_CNT<=BLK_CNT+1 (wraps 255->0); go to DONE.
REQ-026 RECV, ONE=1, WCNT!=32: ERR<=1; go to FAULT.
REQ-027 RECV, STATE=0: ABORT=1 for exactly one cycle; VALID stays 0; go to IDLE.
REQ-028 DONE: no writes; hold VALID=1; STATE=0 -> IDLE.
REQ-029 FAULT: no writes; ERR held at 1; STATE=0 -> IDLE; ERR clears only on CLR or the next legal block start.
REQ-030 Precedence within RECV: STATE=0 over ONE=1 over the COUNT check.
REQ-031 Read: DOUT<=buffer[RADDR] each cycle, one-cycle latency, independent of FSM state.
REQ-032 Read-during-write to the same address: DOUT returns the pre-write data.

Reset
REQ-033 CLR=1 at a clock edge forces IDLE, EXP=0, WCNT=0, VALID=0, ERR=0, ABORT=0, BLK_CNT=0, DOUT=0; CLR overrides all other inputs.
REQ-034 CLR does not clear buffer contents.
REQ-035 CLR asserted mid-block discards the block without an ABORT pulse.

Verification
REQ-036 Nominal block: STATE=1 with COUNT 0..31, DIN=COUNT[1:0], then ONE=1 -> VALID=1, BLK_CNT=1, ERR=0; RADDR=5 -> DOUT=2'b01 on the next cycle.
REQ-037 Skipped address: COUNT 0,1,2,4 -> ERR=1 in the cycle after COUNT=4, state FAULT, address 4 not written; STATE=0 -> IDLE with ERR still 1.
REQ-038 Abort: STATE drops after COUNT=10 -> ABORT high for one cycle, VALID=0, BLK_CNT unchanged.
REQ-039 Premature ONE: ONE=1 after 20 writes -> ERR=1, VALID=0.
REQ-040 Back-to-back: two nominal blocks separated by one STATE=0 cycle -> VALID clears at the start of block 2 and re-asserts after it; BLK_CNT=2; 256 blocks -> BLK_CNT=0.
REQ-041 CLR at COUNT=15 -> all outputs at reset values the next cycle; a following nominal block completes with VALID=1.
